nf_axis_port_arbiter: RTL and testbench

Packet-granular round-robin arbiter merging up to four MAC-side receive AXI4-Stream channels into one 256-bit datapath stream toward the output-port lookup stage. On the first beat of every packet it overwrites the tuser source-port field with the NetFPGA one-hot code of the winning channel; all other beats pass through unchanged. This replaces per-interface default-source-port stamping with one parametrised block serving N interfaces.

---
 rtl/nf_axis_port_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_nf_axis_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_axis_port_arbiter.sv
// nf_axis_port_arbiter
// Packet-granular round-robin merge of up to four receive AXI4-Stream channels
// into one output stream behind a single output register stage. The first beat
// of every packet has tuser[23:16] overwritten with the one-hot source-port code
// of the winning channel (when C_DEFAULT_VALUE_ENABLE is nonzero).
// Optional feature macro: NF_AXIS_ARB_PKT_COUNT_EN adds per-channel packet counters.
module nf_axis_port_arbiter #(
    parameter int C_NUM_PORTS            = 4,
    parameter int C_DATA_WIDTH           = 256,
    parameter int C_TUSER_WIDTH          = 128,
    parameter int C_DEFAULT_VALUE_ENABLE = 1
) (
    input  logic                                  axi_aclk,
    input  logic                                  axi_aresetn,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                s_axis_tvalid,
    output logic [C_NUM_PORTS-1:0]                s_axis_tready,
    input  logic [C_NUM_PORTS-1:0]                s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]             m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]              m_axis_tuser,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic [C_NUM_PORTS*32-1:0]             pkt_count
);

    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam logic [1:0] LAST_PORT = 2'(C_NUM_PORTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // NetFPGA source-port code: channel g maps to bit 2*g of the byte.
    function automatic logic [7:0] stamp_code(input logic [1:0] g);
        return 8'h01 << {g, 1'b0};
    endfunction

    // Replace the source-port byte, leaving every other tuser bit intact.
    function automatic logic [C_TUSER_WIDTH-1:0] stamp_tuser(
        input logic [C_TUSER_WIDTH-1:0] u,
        input logic [1:0]               g
    );
        logic [C_TUSER_WIDTH-1:0] r;
        r        = u;
        r[23:16] = stamp_code(g);
        return r;
    endfunction

    state_t                        state_r;
    state_t                        next_state_s;
    logic [1:0]                    grant_r;
    logic [1:0]                    last_grant_r;
    logic                          first_r;
    logic [1:0]                    pick_idx_s;
    logic                          pick_found_s;
    logic                          sel_tvalid_s;
    logic                          sel_tlast_s;
    logic [C_DATA_WIDTH-1:0]       sel_tdata_s;
    logic [STRB_W-1:0]             sel_tstrb_s;
    logic [C_TUSER_WIDTH-1:0]      sel_tuser_s;
    logic                          ready_s;
    logic                          accept_s;
    logic [C_DATA_WIDTH-1:0]       m_tdata_r;
    logic [STRB_W-1:0]             m_tstrb_r;
    logic [C_TUSER_WIDTH-1:0]      m_tuser_r;
    logic                          m_tvalid_r;
    logic                          m_tlast_r;

    // Round-robin search starting after the previous winner; the lowest offset wins.
    always_comb begin
        int                     cand;
        logic [C_NUM_PORTS-1:0] vshift;
        pick_found_s = 1'b0;
        pick_idx_s   = 2'd0;
        cand         = 0;
        vshift       = '0;
        for (int k = C_NUM_PORTS; k >= 1; k--) begin
            cand         = (int'(last_grant_r) + k) % C_NUM_PORTS;
            vshift       = s_axis_tvalid >> cand;
            pick_idx_s   = vshift[0] ? 2'(cand) : pick_idx_s;
            pick_found_s = pick_found_s | vshift[0];
        end
    end

    // Mux the granted channel's beat out of the flattened input buses.
    always_comb begin
        logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]  data_sh;
        logic [C_NUM_PORTS*STRB_W-1:0]        strb_sh;
        logic [C_NUM_PORTS*C_TUSER_WIDTH-1:0] user_sh;
        logic [C_NUM_PORTS-1:0]               valid_sh;
        logic [C_NUM_PORTS-1:0]               last_sh;
        data_sh      = s_axis_tdata  >> (32'(grant_r) * C_DATA_WIDTH);
        strb_sh      = s_axis_tstrb  >> (32'(grant_r) * STRB_W);
        user_sh      = s_axis_tuser  >> (32'(grant_r) * C_TUSER_WIDTH);
        valid_sh     = s_axis_tvalid >> grant_r;
        last_sh      = s_axis_tlast  >> grant_r;
        sel_tdata_s  = data_sh[C_DATA_WIDTH-1:0];
        sel_tstrb_s  = strb_sh[STRB_W-1:0];
        sel_tuser_s  = user_sh[C_TUSER_WIDTH-1:0];
        sel_tvalid_s = valid_sh[0];
        sel_tlast_s  = last_sh[0];
    end

    // Handshake: only the granted channel sees tready, and only while the output register can take a beat.
    always_comb begin
        ready_s  = !m_tvalid_r || m_axis_tready;
        accept_s = (state_r == ST_BUSY) && sel_tvalid_s && ready_s;
        if ((state_r == ST_BUSY) && ready_s) begin
            s_axis_tready = C_NUM_PORTS'(1'b1) << grant_r;
        end else begin
            s_axis_tready = '0;
        end
    end

    // State register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state: grab a channel in IDLE, release it on the accepted tlast beat.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept_s && sel_tlast_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Grant bookkeeping and first-beat flag for source-port stamping.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            grant_r      <= 2'd0;
            last_grant_r <= LAST_PORT;
            first_r      <= 1'b0;
        end else if ((state_r == ST_IDLE) && pick_found_s) begin
            grant_r <= pick_idx_s;
            first_r <= 1'b1;
        end else if (accept_s) begin
            first_r <= 1'b0;
            if (sel_tlast_s) begin
                last_grant_r <= grant_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end else begin
            first_r <= first_r;
        end
    end

    // Output register: load on accept (even while draining), else clear valid once taken.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            m_tdata_r  <= '0;
            m_tstrb_r  <= '0;
            m_tuser_r  <= '0;
            m_tlast_r  <= 1'b0;
            m_tvalid_r <= 1'b0;
        end else if (accept_s) begin
            m_tdata_r  <= sel_tdata_s;
            m_tstrb_r  <= sel_tstrb_s;
            m_tuser_r  <= ((C_DEFAULT_VALUE_ENABLE != 0) && first_r) ?
                          stamp_tuser(sel_tuser_s, grant_r) : sel_tuser_s;
            m_tlast_r  <= sel_tlast_s;
            m_tvalid_r <= 1'b1;
        end else if (m_tvalid_r && m_axis_tready) begin
            m_tvalid_r <= 1'b0;
        end else begin
            m_tvalid_r <= m_tvalid_r;
        end
    end

    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tstrb  = m_tstrb_r;
    assign m_axis_tuser  = m_tuser_r;
    assign m_axis_tlast  = m_tlast_r;
    assign m_axis_tvalid = m_tvalid_r;

`ifdef NF_AXIS_ARB_PKT_COUNT_EN
    for (genvar i = 0; i < C_NUM_PORTS; i++) begin : g_cnt
        logic [31:0] count_r;
        // Count packets whose final beat is accepted from this channel; wraps naturally.
        always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
                count_r <= 32'd0;
            end else if (accept_s && sel_tlast_s && (grant_r == 2'(i))) begin
                count_r <= count_r + 32'd1;
            end else begin
                count_r <= count_r;
            end
        end
        assign pkt_count[32*i +: 32] = count_r;
    end
`else
    assign pkt_count = {(C_NUM_PORTS*32){1'b0}};
`endif

endmodule

// File: tb/tb_nf_axis_port_arbiter.sv
// Directed bench for nf_axis_port_arbiter: a packet table plus hand sequences
// for fairness, backpressure, mid-packet reset, counters and a 1-port,
// no-stamping instance.
module tb_nf_axis_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*SW-1:0]  s_tstrb;
    logic [NP*UW-1:0]  s_tuser;
    logic [NP-1:0]     s_tvalid, s_tready, s_tlast;
    logic [DW-1:0]     m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid, m_tready, m_tlast;
    logic [NP*32-1:0]  pkt_count;

    logic [DW-1:0]     d1_s_tdata;
    logic [SW-1:0]     d1_s_tstrb;
    logic [UW-1:0]     d1_s_tuser;
    logic [0:0]        d1_s_tvalid, d1_s_tready, d1_s_tlast;
    logic [DW-1:0]     d1_m_tdata;
    logic [SW-1:0]     d1_m_tstrb;
    logic [UW-1:0]     d1_m_tuser;
    logic              d1_m_tvalid, d1_m_tready, d1_m_tlast;
    logic [31:0]       d1_pkt_count;

    always #5 clk = ~clk;

    nf_axis_port_arbiter #(
        .C_NUM_PORTS(NP), .C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW), .C_DEFAULT_VALUE_ENABLE(1)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .pkt_count(pkt_count)
    );

    nf_axis_port_arbiter #(
        .C_NUM_PORTS(1), .C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW), .C_DEFAULT_VALUE_ENABLE(0)
    ) dut1 (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .s_axis_tdata(d1_s_tdata), .s_axis_tstrb(d1_s_tstrb), .s_axis_tuser(d1_s_tuser),
        .s_axis_tvalid(d1_s_tvalid), .s_axis_tready(d1_s_tready), .s_axis_tlast(d1_s_tlast),
        .m_axis_tdata(d1_m_tdata), .m_axis_tstrb(d1_m_tstrb), .m_axis_tuser(d1_m_tuser),
        .m_axis_tvalid(d1_m_tvalid), .m_axis_tready(d1_m_tready), .m_axis_tlast(d1_m_tlast),
        .pkt_count(d1_pkt_count)
    );

    typedef struct {
        logic [31:0]   word;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
        int            cyc;
    } obs_t;

    typedef struct {
        int          ch;
        int          nbeats;
        logic [7:0]  hi;
        logic [15:0] lo;
        logic [7:0]  exp_code;
    } vec_t;

    beat_t chq [NP][$];
    beat_t q1[$];
    obs_t  olog[$];
    obs_t  olog1[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    logic  rdy_toggle = 1'b0;
    logic  prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [UW-1:0] prev_user;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int ch, input int pkt, input int b, input logic last,
                                 input logic [7:0] hi, input logic [15:0] lo);
        beat_t x;
        x.word = {8'(ch), 8'(pkt), 8'(b), 8'h5A};
        x.user = {x.word, x.word, x.word, 8'h3C, hi, lo};
        x.last = last;
        return x;
    endfunction

    task automatic push_pkt(input int ch, input int pkt, input int n, input logic [7:0] hi,
                            input logic [15:0] lo);
        for (int b = 0; b < n; b++) chq[ch].push_back(mk(ch, pkt, b, (b == n - 1), hi, lo));
    endtask

    task automatic push_pkt1(input int pkt, input int n, input logic [7:0] hi, input logic [15:0] lo);
        for (int b = 0; b < n; b++) q1.push_back(mk(0, pkt, b, (b == n - 1), hi, lo));
    endtask

    task automatic drive_idle();
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
        d1_s_tvalid = 1'b0; d1_s_tlast = 1'b0; d1_s_tdata = '0; d1_s_tstrb = '0; d1_s_tuser = '0;
    endtask

    // One clock: drive queue heads at negedge, sample just after, retire accepted beats at posedge.
    task automatic step();
        logic [NP-1:0] acc;
        logic          acc1;
        obs_t          o;
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            if (chq[i].size() > 0) begin
                s_tvalid[i]           = 1'b1;
                s_tlast[i]            = chq[i][0].last;
                s_tdata[i*DW +: DW]   = {8{chq[i][0].word}};
                s_tstrb[i*SW +: SW]   = chq[i][0].word;
                s_tuser[i*UW +: UW]   = chq[i][0].user;
            end else begin
                s_tvalid[i]           = 1'b0;
                s_tlast[i]            = 1'b0;
                s_tdata[i*DW +: DW]   = '0;
                s_tstrb[i*SW +: SW]   = '0;
                s_tuser[i*UW +: UW]   = '0;
            end
        end
        if (q1.size() > 0) begin
            d1_s_tvalid = 1'b1; d1_s_tlast = q1[0].last;
            d1_s_tdata = {8{q1[0].word}}; d1_s_tstrb = q1[0].word; d1_s_tuser = q1[0].user;
        end else begin
            d1_s_tvalid = 1'b0; d1_s_tlast = 1'b0;
            d1_s_tdata = '0; d1_s_tstrb = '0; d1_s_tuser = '0;
        end
        m_tready    = rdy_toggle ? ((cyc % 2) == 0) : 1'b1;
        d1_m_tready = 1'b1;
        #1;
        if (prev_stall) begin
            chk("stall_hold_data", m_tdata, prev_data);
            chk("stall_hold_user", DW'(m_tuser), DW'(prev_user));
            chk("stall_hold_valid", DW'(m_tvalid), DW'(1'b1));
        end
        chk("tready_onehot0", DW'($onehot0(s_tready)), DW'(1'b1));
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_user  = m_tuser;
        acc  = s_tvalid & s_tready;
        acc1 = d1_s_tvalid[0] & d1_s_tready[0];
        if (m_tvalid && m_tready) begin
            o.data = m_tdata; o.strb = m_tstrb; o.user = m_tuser; o.last = m_tlast; o.cyc = cyc;
            olog.push_back(o);
        end
        if (d1_m_tvalid && d1_m_tready) begin
            o.data = d1_m_tdata; o.strb = d1_m_tstrb; o.user = d1_m_tuser; o.last = d1_m_tlast;
            o.cyc = cyc;
            olog1.push_back(o);
        end
        @(posedge clk);
        for (int i = 0; i < NP; i++) if (acc[i]) void'(chq[i].pop_front());
        if (acc1) void'(q1.pop_front());
        cyc++;
    endtask

    task automatic wait_out(input string name, input int n, input logic which);
        int guard = 0;
        while (((which ? olog1.size() : olog.size()) < n) && guard < 300) begin
            step();
            guard++;
        end
        chk({name, "_beats_seen"}, DW'(which ? olog1.size() : olog.size()), DW'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < NP; i++) chq[i].delete();
        q1.delete();
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        olog.delete();
        olog1.delete();
        prev_stall = 1'b0;
        rdy_toggle = 1'b0;
    endtask

    // Compare beats first_b..n-1 of one packet against the log starting at base.
    task automatic check_pkt(input string nm, input int base, input int ch, input int pkt,
                             input int first_b, input int n, input logic [7:0] hi,
                             input logic [15:0] lo, input logic [7:0] code, input logic stamp,
                             input logic which);
        beat_t         e;
        obs_t          o;
        logic [UW-1:0] eu;
        for (int b = first_b; b < n; b++) begin
            e  = mk(ch, pkt, b, (b == n - 1), hi, lo);
            o  = which ? olog1[base + b - first_b] : olog[base + b - first_b];
            eu = e.user;
            if (stamp && (b == first_b)) eu[23:16] = code;
            chk({nm, "_data"}, o.data, {8{e.word}});
            chk({nm, "_strb"}, DW'(o.strb), DW'(e.word));
            chk({nm, "_user"}, DW'(o.user), DW'(eu));
            chk({nm, "_last"}, DW'(o.last), DW'(e.last));
        end
    endtask

    initial begin
        vec_t vecs [5];
        int   ord_ch [5];
        int   ord_pkt [5];
        int   cnt_ch [7];
        logic [31:0] exp_c0, exp_c1;

        vecs[0] = '{2, 3, 8'hFF, 16'd96, 8'h10};
        vecs[1] = '{3, 1, 8'hFF, 16'd7,  8'h40};
        vecs[2] = '{3, 1, 8'h00, 16'd8,  8'h40};
        vecs[3] = '{0, 2, 8'hAB, 16'd1,  8'h01};
        vecs[4] = '{1, 2, 8'h55, 16'd2,  8'h04};
        ord_ch  = '{0, 1, 2, 3, 0};
        ord_pkt = '{0, 0, 0, 0, 1};
        cnt_ch  = '{0, 1, 0, 1, 1, 1, 1};

        // Reset hold with every channel requesting.
        rst_n = 1'b0;
        drive_idle();
        m_tready = 1'b1; d1_m_tready = 1'b1;
        s_tvalid = 4'hF; s_tlast = 4'hF; d1_s_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_m_tvalid", DW'(m_tvalid), DW'(1'b0));
        chk("rst_m_tlast", DW'(m_tlast), DW'(1'b0));
        chk("rst_m_tdata", m_tdata, {DW{1'b0}});
        chk("rst_m_tstrb", DW'(m_tstrb), {DW{1'b0}});
        chk("rst_m_tuser", DW'(m_tuser), {DW{1'b0}});
        chk("rst_s_tready", DW'(s_tready), {DW{1'b0}});
        chk("rst_pkt_count", DW'(pkt_count), {DW{1'b0}});
        chk("rst_d1_tvalid", DW'(d1_m_tvalid), DW'(1'b0));
        drive_idle();
        rst_n = 1'b1;

        // Released with nobody requesting: nothing moves.
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk("idle_s_tready", DW'(s_tready), {DW{1'b0}});
            chk("idle_m_tvalid", DW'(m_tvalid), DW'(1'b0));
        end

        // Packet table, one requester at a time.
        for (int v = 0; v < 5; v++) begin
            olog.delete();
            push_pkt(vecs[v].ch, v, vecs[v].nbeats, vecs[v].hi, vecs[v].lo);
            wait_out("table", vecs[v].nbeats, 1'b0);
            check_pkt($sformatf("table%0d", v), 0, vecs[v].ch, v, 0, vecs[v].nbeats,
                      vecs[v].hi, vecs[v].lo, vecs[v].exp_code, 1'b1, 1'b0);
        end

        // Round-robin fairness with every channel backlogged.
        do_reset();
        push_pkt(0, 0, 2, 8'h11, 16'd0);
        push_pkt(0, 1, 2, 8'h11, 16'd0);
        push_pkt(1, 0, 2, 8'h11, 16'd1);
        push_pkt(2, 0, 2, 8'h11, 16'd2);
        push_pkt(3, 0, 2, 8'h11, 16'd3);
        wait_out("fair", 10, 1'b0);
        for (int p = 0; p < 5; p++) begin
            check_pkt($sformatf("fair%0d", p), 2 * p, ord_ch[p], ord_pkt[p], 0, 2, 8'h11,
                      16'(ord_ch[p]), 8'h01 << (2 * ord_ch[p]), 1'b1, 1'b0);
        end
        for (int k = 1; k < 10; k++) begin
            chk("fair_gap", DW'(olog[k].cyc - olog[k-1].cyc), DW'(((k % 2) == 1) ? 1 : 2));
        end

        // Backpressure: output ready toggles every cycle.
        do_reset();
        rdy_toggle = 1'b1;
        push_pkt(1, 9, 4, 8'h77, 16'd44);
        wait_out("bp", 4, 1'b0);
        repeat (6) step();
        chk("bp_no_dup", DW'(olog.size()), DW'(4));
        check_pkt("bp", 0, 1, 9, 0, 4, 8'h77, 16'd44, 8'h04, 1'b1, 1'b0);
        rdy_toggle = 1'b0;

        // Packet counters: interleaved requests on channels 0 and 1.
        do_reset();
        for (int p = 0; p < 5; p++) push_pkt(1, p, 1, 8'h00, 16'd9);
        for (int p = 0; p < 2; p++) push_pkt(0, p, 1, 8'h00, 16'd9);
        wait_out("cnt", 7, 1'b0);
        for (int k = 0; k < 7; k++) begin
            chk("cnt_order_ch", DW'(olog[k].data[31:24]), DW'(cnt_ch[k]));
        end
        repeat (2) step();
        #1;
`ifdef NF_AXIS_ARB_PKT_COUNT_EN
        exp_c0 = 32'd2;
        exp_c1 = 32'd5;
`else
        exp_c0 = 32'd0;
        exp_c1 = 32'd0;
`endif
        chk("cnt_ch0", DW'(pkt_count[31:0]), DW'(exp_c0));
        chk("cnt_ch1", DW'(pkt_count[63:32]), DW'(exp_c1));
        chk("cnt_ch23", DW'(pkt_count[127:64]), {DW{1'b0}});

        // Asynchronous reset mid-packet; the tail restarts as a new, stamped packet.
        olog.delete();
        push_pkt(1, 7, 4, 8'h22, 16'd5);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", DW'(m_tvalid), DW'(1'b0));
        chk("midrst_m_tlast", DW'(m_tlast), DW'(1'b0));
        chk("midrst_s_tready", DW'(s_tready), {DW{1'b0}});
        chk("midrst_pkt_count", DW'(pkt_count), {DW{1'b0}});
        @(negedge clk);
        rst_n = 1'b1;
        olog.delete();
        prev_stall = 1'b0;
        wait_out("midrst", 2, 1'b0);
        check_pkt("midrst", 0, 1, 7, 2, 4, 8'h22, 16'd5, 8'h04, 1'b1, 1'b0);

        // Single-port instance, stamping disabled: register stage with one idle cycle.
        do_reset();
        push_pkt1(0, 2, 8'hFF, 16'd3);
        push_pkt1(1, 1, 8'hFF, 16'd4);
        wait_out("p1", 3, 1'b1);
        check_pkt("p1a", 0, 0, 0, 0, 2, 8'hFF, 16'd3, 8'h00, 1'b0, 1'b1);
        check_pkt("p1b", 2, 0, 1, 0, 1, 8'hFF, 16'd4, 8'h00, 1'b0, 1'b1);
        chk("p1_gap_in_pkt", DW'(olog1[1].cyc - olog1[0].cyc), DW'(1));
        chk("p1_gap_between", DW'(olog1[2].cyc - olog1[1].cyc), DW'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
